// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one cmd_* request into an AXI4-Lite
// read or write and reports completion on rsp_*. Every output comes straight from a register.
module axi4_lite_master #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

    state_t                     state_reg;
    logic                       cmd_ready_reg;
    logic                       rsp_valid_reg;
    logic [DATA_WIDTH-1:0]      rsp_rdata_reg;
    logic [1:0]                 rsp_resp_reg;
    logic [ADDRESS_WIDTH-1:0]   awaddr_reg;
    logic                       awvalid_reg;
    logic [DATA_WIDTH-1:0]      wdata_reg;
    logic [DATA_WIDTH/8-1:0]    wstrb_reg;
    logic                       wvalid_reg;
    logic                       bready_reg;
    logic [ADDRESS_WIDTH-1:0]   araddr_reg;
    logic                       arvalid_reg;
    logic                       rready_reg;

    // A write channel counts as done if it already handshook or is handshaking now.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_reg || M_AXI_AWREADY;
    assign w_done  = !wvalid_reg  || M_AXI_WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;
            awaddr_reg    <= '0;
            awvalid_reg   <= 1'b0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            araddr_reg    <= '0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready_reg) begin
                        cmd_ready_reg <= 1'b0;
                        if (cmd_write) begin
                            awaddr_reg  <= cmd_addr;
                            wdata_reg   <= cmd_wdata;
                            wstrb_reg   <= cmd_wstrb;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= WRITE;
                        end else begin
                            araddr_reg  <= cmd_addr;
                            arvalid_reg <= 1'b1;
                            state_reg   <= RADDR;
                        end
                    end
                end
                WRITE: begin
                    if (awvalid_reg && M_AXI_AWREADY) awvalid_reg <= 1'b0;
                    if (wvalid_reg && M_AXI_WREADY)   wvalid_reg  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_reg <= 1'b1;
                        state_reg  <= WRESP;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID && bready_reg) begin
                        bready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_resp_reg  <= M_AXI_BRESP;
                        rsp_rdata_reg <= '0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                RADDR: begin
                    if (arvalid_reg && M_AXI_ARREADY) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RDATA;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID && rready_reg) begin
                        rready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_resp_reg  <= M_AXI_RRESP;
                        rsp_rdata_reg <= M_AXI_RDATA;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;
    assign M_AXI_AWADDR  = awaddr_reg;
    assign M_AXI_AWVALID = awvalid_reg;
    assign M_AXI_WDATA   = wdata_reg;
    assign M_AXI_WSTRB   = wstrb_reg;
    assign M_AXI_WVALID  = wvalid_reg;
    assign M_AXI_BREADY  = bready_reg;
    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_ARVALID = arvalid_reg;
    assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: the bench plays the AXI slave cycle by cycle,
// drives and samples on the falling edge, and checks against hand-derived values.
module tb_axi4_lite_master;

    logic        ACLK;
    logic        ARESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    int n_cmp = 0;
    int n_err = 0;

    axi4_lite_master #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        repeat (5000) @(posedge ACLK);
        $display("FAIL watchdog: simulation still running after 5000 cycles, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        @(negedge ACLK);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready);
        end
        n_cmp++;
        if ({M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
             M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, rsp_rdata, rsp_resp} !== '0) begin
            n_err++; $display("FAIL reset outputs: some output nonzero, want all 0 (aw=%b w=%b b=%b ar=%b r=%b rsp=%b)",
                              M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid);
        end
        ARESET = 1'b0;
        $display("reset released");
    endtask

    task automatic test_write_zero_wait(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge ACLK);  // cycle 0: accept
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL wr0 idle cmd_ready: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        @(negedge ACLK);  // cycle 1
        cmd_valid = 1'b0;
        n_cmp++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, cmd_ready} !== 4'b1100) begin
            n_err++; $display("FAIL wr0 c1 aw/w/b/cmd_ready: got %b want 1100",
                              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, cmd_ready});
        end
        n_cmp++;
        if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !== {addr, data, strb}) begin
            n_err++; $display("FAIL wr0 c1 payload: got %h/%h/%h want %h/%h/%h",
                              M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, addr, data, strb);
        end
        @(negedge ACLK);  // cycle 2
        n_cmp++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b001) begin
            n_err++; $display("FAIL wr0 c2 aw/w/b: got %b want 001", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY});
        end
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
        @(negedge ACLK);  // cycle 3
        M_AXI_BVALID = 1'b0;
        n_cmp++;
        if ({rsp_valid, M_AXI_BREADY, cmd_ready, rsp_resp} !== 5'b10100) begin
            n_err++; $display("FAIL wr0 c3 rsp_valid/bready/cmd_ready/resp: got %b want 10100",
                              {rsp_valid, M_AXI_BREADY, cmd_ready, rsp_resp});
        end
        n_cmp++;
        if (rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL wr0 c3 rsp_rdata: got %h want 00000000", rsp_rdata);
        end
        @(negedge ACLK);  // cycle 4
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL wr0 c4 rsp_valid pulse width: got %b want 0", rsp_valid);
        end
        $display("write addr=%h data=%h strb=%h zero-wait done", addr, data, strb);
    endtask

    task automatic test_read_delayed();
        @(negedge ACLK);  // cycle 0
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4;
        M_AXI_ARREADY = 1'b0;
        @(negedge ACLK);  // cycle 1
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if ({M_AXI_ARVALID, M_AXI_RREADY, M_AXI_ARADDR} !== {2'b10, 32'h4}) begin
                n_err++; $display("FAIL rd c%0d arvalid/rready/araddr: got %b%b/%h want 10/00000004",
                                  k, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_ARADDR);
            end
            if (k == 4) M_AXI_ARREADY = 1'b1;
            @(negedge ACLK);
        end
        M_AXI_ARREADY = 1'b0;  // now at cycle 5
        for (int k = 5; k <= 7; k++) begin
            n_cmp++;
            if ({M_AXI_ARVALID, M_AXI_RREADY, rsp_valid} !== 3'b010) begin
                n_err++; $display("FAIL rd c%0d arvalid/rready/rsp_valid: got %b want 010",
                                  k, {M_AXI_ARVALID, M_AXI_RREADY, rsp_valid});
            end
            if (k == 7) begin
                M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hDEADBEEF; M_AXI_RRESP = 2'b00;
            end
            @(negedge ACLK);
        end
        M_AXI_RVALID = 1'b0;  // cycle 8
        n_cmp++;
        if ({rsp_valid, M_AXI_RREADY, cmd_ready, rsp_resp} !== 5'b10100) begin
            n_err++; $display("FAIL rd c8 rsp_valid/rready/cmd_ready/resp: got %b want 10100",
                              {rsp_valid, M_AXI_RREADY, cmd_ready, rsp_resp});
        end
        n_cmp++;
        if (rsp_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL rd c8 rsp_rdata: got %h want deadbeef", rsp_rdata);
        end
        @(negedge ACLK);  // cycle 9
        n_cmp++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL rd c9 pulse/hold: got %b/%h want 0/deadbeef", rsp_valid, rsp_rdata);
        end
        $display("read addr=00000004 data=%h resp=%b delayed slave done", rsp_rdata, rsp_resp);
    endtask

    task automatic test_write_split(input bit aw_first);
        logic aw_exp, w_exp;
        @(negedge ACLK);  // cycle 0
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h18; cmd_wdata = 32'hCAFE0001; cmd_wstrb = 4'h6;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        @(negedge ACLK);  // cycle 1
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            aw_exp = aw_first ? (k == 1) : 1'b1;
            w_exp  = aw_first ? 1'b1 : (k == 1);
            n_cmp++;
            if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== {aw_exp, w_exp, 1'b0}) begin
                n_err++; $display("FAIL split%0d c%0d aw/w/b: got %b want %b", aw_first, k,
                                  {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, {aw_exp, w_exp, 1'b0});
            end
            n_cmp++;
            if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !== {32'h18, 32'hCAFE0001, 4'h6}) begin
                n_err++; $display("FAIL split%0d c%0d payload: got %h/%h/%h want 00000018/cafe0001/6",
                                  aw_first, k, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB);
            end
            M_AXI_AWREADY = aw_first ? (k == 1) : (k == 4);
            M_AXI_WREADY  = aw_first ? (k == 4) : (k == 1);
            @(negedge ACLK);
        end
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;  // cycle 5
        n_cmp++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid} !== 4'b0010) begin
            n_err++; $display("FAIL split%0d c5 aw/w/b/rsp: got %b want 0010", aw_first,
                              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid});
        end
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b11;
        @(negedge ACLK);  // cycle 6
        M_AXI_BVALID = 1'b0;
        n_cmp++;
        if ({rsp_valid, M_AXI_BREADY, rsp_resp, rsp_rdata} !== {4'b1011, 32'h0}) begin
            n_err++; $display("FAIL split%0d c6 rsp_valid/bready/resp/rdata: got %b%b%b/%h want 1011/00000000",
                              aw_first, rsp_valid, M_AXI_BREADY, rsp_resp, rsp_rdata);
        end
        @(negedge ACLK);  // cycle 7
        n_cmp++;
        if ({rsp_valid, M_AXI_BREADY, cmd_ready} !== 3'b001) begin
            n_err++; $display("FAIL split%0d c7 rsp_valid/bready/cmd_ready: got %b want 001", aw_first,
                              {rsp_valid, M_AXI_BREADY, cmd_ready});
        end
        $display("write split %s first, resp=%b done", aw_first ? "AW" : "W", rsp_resp);
    endtask

    task automatic test_back_to_back();
        @(negedge ACLK);  // cycle 0
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'h12345678; cmd_wstrb = 4'h3;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_ARREADY = 1'b0;
        @(negedge ACLK);  // cycle 1: the read is queued on cmd_* while the master is busy
        cmd_write = 1'b0; cmd_addr = 32'hC;
        n_cmp++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, cmd_ready} !== 3'b110) begin
            n_err++; $display("FAIL b2b c1 aw/w/cmd_ready: got %b want 110", {M_AXI_AWVALID, M_AXI_WVALID, cmd_ready});
        end
        @(negedge ACLK);  // cycle 2
        n_cmp++;
        if ({M_AXI_BREADY, M_AXI_ARVALID, M_AXI_AWADDR} !== {2'b10, 32'h8}) begin
            n_err++; $display("FAIL b2b c2 bready/arvalid/awaddr: got %b%b/%h want 10/00000008",
                              M_AXI_BREADY, M_AXI_ARVALID, M_AXI_AWADDR);
        end
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
        @(negedge ACLK);  // cycle 3: write completes, read accepted this cycle
        M_AXI_BVALID = 1'b0;
        n_cmp++;
        if ({rsp_valid, cmd_ready, rsp_resp} !== 4'b1100) begin
            n_err++; $display("FAIL b2b c3 rsp_valid/cmd_ready/resp: got %b want 1100", {rsp_valid, cmd_ready, rsp_resp});
        end
        M_AXI_ARREADY = 1'b1;
        @(negedge ACLK);  // cycle 4
        cmd_valid = 1'b0;
        n_cmp++;
        if ({M_AXI_ARVALID, cmd_ready, rsp_valid, M_AXI_ARADDR} !== {3'b100, 32'hC}) begin
            n_err++; $display("FAIL b2b c4 arvalid/cmd_ready/rsp_valid/araddr: got %b%b%b/%h want 100/0000000c",
                              M_AXI_ARVALID, cmd_ready, rsp_valid, M_AXI_ARADDR);
        end
        @(negedge ACLK);  // cycle 5
        n_cmp++;
        if ({M_AXI_ARVALID, M_AXI_RREADY} !== 2'b01) begin
            n_err++; $display("FAIL b2b c5 arvalid/rready: got %b want 01", {M_AXI_ARVALID, M_AXI_RREADY});
        end
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hA5A50F0F; M_AXI_RRESP = 2'b00;
        @(negedge ACLK);  // cycle 6
        M_AXI_RVALID = 1'b0; M_AXI_ARREADY = 1'b0; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_rdata, rsp_resp} !== {1'b1, 32'hA5A50F0F, 2'b00}) begin
            n_err++; $display("FAIL b2b c6 rsp_valid/rdata/resp: got %b/%h/%b want 1/a5a50f0f/00",
                              rsp_valid, rsp_rdata, rsp_resp);
        end
        $display("back-to-back write addr=00000008 then read addr=0000000c data=%h done", rsp_rdata);
    endtask

    task automatic test_read_error_spurious_b();
        @(negedge ACLK);  // cycle 0
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
        M_AXI_ARREADY = 1'b1;
        @(negedge ACLK);  // cycle 1
        cmd_valid = 1'b0;
        n_cmp++;
        if ({M_AXI_ARVALID, M_AXI_BREADY} !== 2'b10) begin
            n_err++; $display("FAIL rderr c1 arvalid/bready: got %b want 10", {M_AXI_ARVALID, M_AXI_BREADY});
        end
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b01;
        @(negedge ACLK);  // cycle 2
        M_AXI_BVALID = 1'b0; M_AXI_ARREADY = 1'b0;
        n_cmp++;
        if ({M_AXI_ARVALID, M_AXI_RREADY, M_AXI_BREADY, rsp_valid} !== 4'b0100) begin
            n_err++; $display("FAIL rderr c2 arvalid/rready/bready/rsp: got %b want 0100",
                              {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_BREADY, rsp_valid});
        end
        M_AXI_RVALID = 1'b1; M_AXI_RRESP = 2'b10; M_AXI_RDATA = 32'h0BAD0BAD;
        M_AXI_BVALID = 1'b1;
        @(negedge ACLK);  // cycle 3
        M_AXI_RVALID = 1'b0;
        n_cmp++;
        if ({rsp_valid, M_AXI_BREADY, rsp_resp, rsp_rdata} !== {4'b1010, 32'h0BAD0BAD}) begin
            n_err++; $display("FAIL rderr c3 rsp_valid/bready/resp/rdata: got %b%b%b/%h want 1010/0bad0bad",
                              rsp_valid, M_AXI_BREADY, rsp_resp, rsp_rdata);
        end
        @(negedge ACLK);  // cycle 4: BVALID still high while idle
        M_AXI_BVALID = 1'b0;
        n_cmp++;
        if ({rsp_valid, M_AXI_BREADY, cmd_ready, rsp_resp} !== 5'b00110) begin
            n_err++; $display("FAIL rderr c4 idle bvalid ignored: got %b want 00110",
                              {rsp_valid, M_AXI_BREADY, cmd_ready, rsp_resp});
        end
        $display("read addr=00000010 resp=%b with spurious BVALID done", rsp_resp);
    endtask

    task automatic test_reset_mid_write();
        @(negedge ACLK);  // cycle 0
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        @(negedge ACLK);  // cycle 1
        cmd_valid = 1'b0;
        M_AXI_AWREADY = 1'b1;
        @(negedge ACLK);  // cycle 2: AW done, W pending
        M_AXI_AWREADY = 1'b0;
        n_cmp++;
        if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b01) begin
            n_err++; $display("FAIL rstmid c2 aw/w before reset: got %b want 01", {M_AXI_AWVALID, M_AXI_WVALID});
        end
        ARESET = 1'b1;
        #1;
        n_cmp++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready} !== 7'b0000001) begin
            n_err++; $display("FAIL rstmid async outputs: got %b want 0000001",
                              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready});
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        M_AXI_WREADY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge ACLK);
            n_cmp++;
            if ({rsp_valid, M_AXI_WVALID, M_AXI_BREADY, cmd_ready} !== 4'b0001) begin
                n_err++; $display("FAIL rstmid post%0d rsp_valid/w/b/cmd_ready: got %b want 0001", k,
                                  {rsp_valid, M_AXI_WVALID, M_AXI_BREADY, cmd_ready});
            end
        end
        M_AXI_WREADY = 1'b0;
        $display("reset mid-write abandoned transaction");
        test_write_zero_wait(32'h24, 32'h0000BEEF, 4'hC);
    endtask

    initial begin
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00; M_AXI_RVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        test_reset();
        test_write_zero_wait(32'h4, 32'hDEADBEEF, 4'hF);
        test_read_delayed();
        test_write_split(1'b1);
        test_write_split(1'b0);
        test_back_to_back();
        test_read_error_spurious_b();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
